// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit unit.
//   - OP_* opcode constants (RISC-V opcode[6:2] encoding)
//   - wb_entry_t: a queued regfile write {int_we, fp_we, rd, data} at default widths
//   - wb_decode(): op -> {int_we, fp_we, sel_mem}
package wb_pkg;

  localparam int unsigned WB_OP_W = 5;
  localparam int unsigned WB_RD_W = 5;
  localparam int unsigned WB_XLEN = 32;

  localparam logic [WB_OP_W-1:0] OP_I_LOAD  = 5'b00000;
  localparam logic [WB_OP_W-1:0] OP_FLW     = 5'b00001;
  localparam logic [WB_OP_W-1:0] OP_I_ARITH = 5'b00100;
  localparam logic [WB_OP_W-1:0] OP_AUIPC   = 5'b00101;
  localparam logic [WB_OP_W-1:0] OP_S_STORE = 5'b01000;
  localparam logic [WB_OP_W-1:0] OP_FSW     = 5'b01001;
  localparam logic [WB_OP_W-1:0] OP_RM_TYPE = 5'b01100;
  localparam logic [WB_OP_W-1:0] OP_LUI     = 5'b01101;
  localparam logic [WB_OP_W-1:0] OP_FTYPE   = 5'b10100;
  localparam logic [WB_OP_W-1:0] OP_BRANCH  = 5'b11000;
  localparam logic [WB_OP_W-1:0] OP_JALR    = 5'b11001;
  localparam logic [WB_OP_W-1:0] OP_JAL     = 5'b11011;
  localparam logic [WB_OP_W-1:0] OP_CSR     = 5'b11100;

  typedef struct packed {
    logic               int_we;
    logic               fp_we;
    logic [WB_RD_W-1:0] rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic int_we;
    logic fp_we;
    logic sel_mem;
  } wb_dec_t;

  function automatic wb_dec_t wb_decode(input logic [WB_OP_W-1:0] op);
    wb_dec_t d;
    d = '0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_I_ARITH, OP_RM_TYPE, OP_CSR: d.int_we = 1'b1;
      OP_I_LOAD: begin
        d.int_we  = 1'b1;
        d.sel_mem = 1'b1;
      end
      OP_FTYPE: d.fp_we = 1'b1;
      OP_FLW: begin
        d.fp_we   = 1'b1;
        d.sel_mem = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source writeback FIFO.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (head), full, empty, count.
// Push and pop may happen in the same cycle; callers never push while full.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback commit unit: NUM_SRC producers each decode op at enqueue into an
// integer or FP regfile write, queue it in a per-source FIFO, and one winner
// per cycle is committed through registered outputs.
// Ports: clk, rst (sync, active-high); per-source in_valid/in_ready/in_op/in_rd/
//        in_alu/in_mem (source i at slice i); commit outputs wb_we, fwb_we,
//        wb_rd, wb_data, wb_src; busy = any FIFO non-empty (registered).
// Config macro: WB_RR_ARB_EN -> round-robin arbitration; otherwise fixed
//               priority with the lowest source index winning.
module wb_commit_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      in_valid,
  output logic [NUM_SRC-1:0]      in_ready,
  input  logic [NUM_SRC*OP_W-1:0] in_op,
  input  logic [NUM_SRC*RD_W-1:0] in_rd,
  input  logic [NUM_SRC*XLEN-1:0] in_alu,
  input  logic [NUM_SRC*XLEN-1:0] in_mem,
  output logic                    wb_we,
  output logic                    fwb_we,
  output logic [RD_W-1:0]         wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic [SRC_W-1:0]        wb_src,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            int_we;
    logic            fp_we;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t             wdata    [NUM_SRC];
  entry_t             head     [NUM_SRC];
  logic [CNT_W-1:0]   cnt      [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, full, empty, nonempty, nonempty_nxt;

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  entry_t             win;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_dec_t         dec;
    logic [RD_W-1:0] rd;
    logic            keep;

    assign dec = wb_decode(in_op[i*OP_W +: OP_W]);
    assign rd  = in_rd[i*RD_W +: RD_W];
    // Stores/branches/unknown ops and integer writes to x0 are consumed without storing.
    assign keep = dec.fp_we | (dec.int_we & (rd != '0));

    assign wdata[i] = '{
      int_we: dec.int_we,
      fp_we:  dec.fp_we,
      rd:     rd,
      data:   dec.sel_mem ? in_mem[i*XLEN +: XLEN] : in_alu[i*XLEN +: XLEN]
    };

    assign in_ready[i] = ~full[i];
    assign push[i]     = in_valid[i] & in_ready[i] & keep;
    assign nonempty[i] = ~empty[i];
    assign pop[i]      = grant_valid & (grant_idx == SRC_W'(i));
    // Occupancy after this edge, so busy can be registered alongside the counts.
    assign nonempty_nxt[i] = push[i] | (cnt[i] > CNT_W'(1)) | ((cnt[i] == CNT_W'(1)) & ~pop[i]);

    wb_src_fifo #(
      .DEPTH  (DEPTH),
      .entry_t(entry_t)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[i]),
      .wdata(wdata[i]),
      .pop  (pop[i]),
      .rdata(head[i]),
      .full (full[i]),
      .empty(empty[i]),
      .count(cnt[i])
    );
  end

`ifdef WB_RR_ARB_EN
  logic [SRC_W-1:0] ptr_q;
  int unsigned      idx;

  // Search begins one past the last granted source.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(ptr_q) + k) % NUM_SRC;
      if (!grant_valid && nonempty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_valid) begin
      ptr_q <= grant_idx;
    end
  end
`else
  // Descending scan so the lowest non-empty index is the last assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      if (nonempty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(k);
      end
    end
  end
`endif

  assign win = head[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      fwb_we  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      busy    <= 1'b0;
    end else begin
      wb_we  <= grant_valid & win.int_we;
      fwb_we <= grant_valid & win.fp_we;
      if (grant_valid) begin
        wb_rd   <= win.rd;
        wb_data <= win.data;
        wb_src  <= grant_idx;
      end
      busy <= |nonempty_nxt;
    end
  end

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Scoreboard bench for wb_commit_arbiter: a queue-level reference model tracks
// each source's pending writes and pushes the expected commit per cycle; a
// separate monitor pops and compares on the opposite clock edge.
module tb_wb_commit_arbiter;
  import wb_pkg::*;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned SRC_W   = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_SRC-1:0]      in_valid, in_ready;
  logic [NUM_SRC*OP_W-1:0] in_op;
  logic [NUM_SRC*RD_W-1:0] in_rd;
  logic [NUM_SRC*XLEN-1:0] in_alu, in_mem;
  logic                    wb_we, fwb_we, busy;
  logic [RD_W-1:0]         wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic [SRC_W-1:0]        wb_src;

  always #5 clk = ~clk;

  wb_commit_arbiter #(
    .NUM_SRC(NUM_SRC), .XLEN(XLEN), .RD_W(RD_W), .OP_W(OP_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem), .wb_we(wb_we), .fwb_we(fwb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_src(wb_src), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            iw;
    bit            fw;
    bit [RD_W-1:0] rd;
    bit [XLEN-1:0] data;
    int            src;
  } exp_t;

  exp_t             pend [NUM_SRC][$];
  exp_t             exp_q[$];
  exp_t             last_m;
  bit [NUM_SRC-1:0] rdy_m;
  bit               busy_m;
  int               ptr_m;
  bit               mon_en = 1'b0;

  // 0: no regfile write, 1: integer, 2: FP
  function automatic int ref_kind(input logic [4:0] op);
    if (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_I_LOAD, OP_I_ARITH, OP_RM_TYPE, OP_CSR})
      return 1;
    if (op inside {OP_FTYPE, OP_FLW}) return 2;
    return 0;
  endfunction

  int               m_win, m_s;
  bit [NUM_SRC-1:0] m_rdy_pre;
  exp_t             m_e;
  logic [4:0]       m_op;

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) pend[s].delete();
      exp_q.delete();
      last_m = '{iw: 0, fw: 0, rd: 0, data: 0, src: 0};
      ptr_m  = 0;
      rdy_m  = '1;
      busy_m = 0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) m_rdy_pre[s] = (pend[s].size() < DEPTH);
      m_win = -1;
`ifdef WB_RR_ARB_EN
      for (int k = 1; k <= NUM_SRC; k++) begin
        m_s = (ptr_m + k) % NUM_SRC;
        if (m_win < 0 && pend[m_s].size() > 0) m_win = m_s;
      end
`else
      for (int s = 0; s < NUM_SRC; s++)
        if (m_win < 0 && pend[s].size() > 0) m_win = s;
`endif
      if (m_win >= 0) begin
        m_e = pend[m_win].pop_front();
        exp_q.push_back(m_e);
        last_m = m_e;
        ptr_m  = m_win;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        m_op = in_op[s*OP_W +: OP_W];
        if (in_valid[s] && m_rdy_pre[s]) begin
          m_e.iw   = (ref_kind(m_op) == 1);
          m_e.fw   = (ref_kind(m_op) == 2);
          m_e.rd   = in_rd[s*RD_W +: RD_W];
          m_e.data = (m_op inside {OP_I_LOAD, OP_FLW}) ? in_mem[s*XLEN +: XLEN]
                                                       : in_alu[s*XLEN +: XLEN];
          m_e.src  = s;
          if (m_e.fw || (m_e.iw && m_e.rd != 0)) pend[s].push_back(m_e);
        end
      end
      busy_m = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
        rdy_m[s] = (pend[s].size() < DEPTH);
        if (pend[s].size() > 0) busy_m = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t c_e;
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 64'(in_ready), 64'(rdy_m));
      check("busy", 64'(busy), 64'(busy_m));
      check("we_exclusive", 64'(wb_we & fwb_we), 64'(0));
      if (exp_q.size() > 0) begin
        c_e = exp_q.pop_front();
        check("commit_wb_we", 64'(wb_we), 64'(c_e.iw));
        check("commit_fwb_we", 64'(fwb_we), 64'(c_e.fw));
        check("commit_rd", 64'(wb_rd), 64'(c_e.rd));
        check("commit_data", 64'(wb_data), 64'(c_e.data));
        check("commit_src", 64'(wb_src), 64'(c_e.src));
      end else begin
        check("idle_wb_we", 64'(wb_we), 64'(0));
        check("idle_fwb_we", 64'(fwb_we), 64'(0));
        check("hold_rd", 64'(wb_rd), 64'(last_m.rd));
        check("hold_data", 64'(wb_data), 64'(last_m.data));
        check("hold_src", 64'(wb_src), 64'(last_m.src));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [4:0] op, input logic [RD_W-1:0] rd,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem);
    in_op[s*OP_W +: OP_W]  = op;
    in_rd[s*RD_W +: RD_W]  = rd;
    in_alu[s*XLEN +: XLEN] = alu;
    in_mem[s*XLEN +: XLEN] = mem;
  endtask

  logic [4:0] op_tab [13];

  task automatic rand_src(input int s);
    logic [RD_W-1:0] rd;
    rd = ($urandom_range(0, 3) == 0) ? '0 : RD_W'($urandom);
    set_src(s, op_tab[$urandom_range(0, 12)], rd, $urandom, $urandom);
  endtask

  initial begin
    op_tab = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_I_LOAD, OP_I_ARITH, OP_RM_TYPE, OP_CSR,
               OP_FTYPE, OP_FLW, OP_S_STORE, OP_BRANCH, 5'b11111};
    rst = 1'b1; in_valid = '0; in_op = '0; in_rd = '0; in_alu = '0; in_mem = '0;
    repeat (3) step();
    mon_en = 1'b1;
    check("reset_ready", 64'(in_ready), 64'(2'b11));
    check("reset_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    step();

    // Single load on src0.
    set_src(0, OP_I_LOAD, 5'd5, 32'h100, 32'hDEADBEEF);
    in_valid = 2'b01;
    step();
    in_valid = '0;
    step();
    check("load_we", 64'(wb_we), 64'(1));
    check("load_rd", 64'(wb_rd), 64'(5));
    check("load_data", 64'(wb_data), 64'hDEADBEEF);
    check("load_src", 64'(wb_src), 64'(0));
    step();

    // FP load to f0 on src1 is a real write.
    set_src(1, OP_FLW, 5'd0, 32'h0, 32'h3F800000);
    in_valid = 2'b10;
    step();
    in_valid = '0;
    step();
    check("flw_fwb_we", 64'(fwb_we), 64'(1));
    check("flw_wb_we", 64'(wb_we), 64'(0));
    check("flw_rd", 64'(wb_rd), 64'(0));
    check("flw_data", 64'(wb_data), 64'h3F800000);
    check("flw_src", 64'(wb_src), 64'(1));
    step();

    // x0 write and a store are dropped.
    set_src(0, OP_I_ARITH, 5'd0, 32'h1234, 32'h0);
    in_valid = 2'b01;
    step();
    check("drop_x0_busy", 64'(busy), 64'(0));
    set_src(0, OP_S_STORE, 5'd7, 32'h5678, 32'h0);
    step();
    check("drop_st_busy", 64'(busy), 64'(0));
    in_valid = '0;
    repeat (2) step();
    check("drop_no_commit", 64'(wb_we | fwb_we), 64'(0));

    // Contention then reset mid-stream.
    for (int c = 0; c < 8; c++) begin
      set_src(0, OP_I_ARITH, RD_W'(c + 1), 32'(c), 32'h0);
      set_src(1, OP_RM_TYPE, RD_W'(c + 9), 32'(c + 100), 32'h0);
      in_valid = 2'b11;
      step();
    end
    rst = 1'b1;
    in_valid = '0;
    step();
    rst = 1'b0;
    check("rst_mid_we", 64'(wb_we), 64'(0));
    check("rst_mid_fwb", 64'(fwb_we), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(in_ready), 64'(2'b11));
    repeat (3) step();

    // Steady 1/cycle stream on src0 alone.
    for (int c = 0; c < 40; c++) begin
      set_src(0, OP_I_ARITH, RD_W'((c % 31) + 1), $urandom, 32'h0);
      in_valid = 2'b01;
      step();
      check("stream_ready0", 64'(in_ready[0]), 64'(1));
      if (c >= 1) check("stream_commit", 64'(wb_we), 64'(1));
    end
    in_valid = '0;
    repeat (3) step();

    // Randomized traffic, light and heavy load phases.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          rand_src(s);
          in_valid[s] = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 95));
        end
        step();
      end
    end

    in_valid = '0;
    repeat (10) step();
    check("drain_busy", 64'(busy), 64'(0));
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
